apb_spi_nor_controller: RTL and testbench
=========================================

Name: apb_spi_nor_controller

Overview:
- APB3 slave that turns each 32-bit APB access into one SPI-style frame to an external NOR flash.
- The flash link is byte-parallel: 8-bit s_mosi/s_miso, one byte per s_clk period, active-low chip select s_css.
- Each frame is 8 bytes: a command byte, 3 address bytes, then 4 data bytes.
- The block sits between the APB interconnect and the flash pins. It stalls the bus with p_ready until the frame completes.

Parameters:
- CLK_DIV, 2, p_clk cycles per s_clk period. Must be even and >=2. Low phase = high phase = CLK_DIV/2 cycles.
- WR_CMD, 8'h02, command byte for APB writes.
- RD_CMD, 8'h01, command byte for APB reads.

Ports:
- p_clk  in  1  single clock for all logic.
- p_reset  in  1  synchronous, active-high reset.
- p_addr  in  32  APB address; p_addr[23:0] is the flash byte address.
- p_write  in  1  1 = write, 0 = read.
- p_sel_x  in  1  APB select.
- p_enable  in  1  APB access phase.
- p_wdata  in  32  APB write data.
- p_rdata  out  32  APB read data.
- p_ready  out  1  APB ready (completion pulse).
- s_mosi  out  8  byte to flash.
- s_miso  in  8  byte from flash.
- s_clk  out  1  flash clock.
- s_css  out  1  flash chip select, active low.

Behaviour:
- Reset values (any cycle with p_reset=1): s_css=1, s_clk=0, s_mosi=0, p_ready=0, p_rdata=0, FSM=IDLE.
- Reset mid-frame aborts the frame. s_css=1 on the next edge, and no p_ready pulse is generated.
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT:
  - Transition happens on a p_clk edge where p_sel_x=1, p_enable=1 and p_ready=0.
  - On that edge the block latches the command (WR_CMD if p_write, else RD_CMD), p_addr[23:0] and p_wdata.
  - It also clears the byte counter and the phase counter.
- SHIFT:
  - s_css=0.
  - Byte k (0..7) occupies CLK_DIV cycles: s_clk=0 for the first CLK_DIV/2 cycles, then 1 for CLK_DIV/2 cycles.
  - s_mosi holds byte k for the whole slot.
  - Byte order: cmd, addr[23:16], addr[15:8], addr[7:0], data[31:24], data[23:16], data[15:8], data[7:0].
  - For reads, bytes 4..7 on s_mosi are 8'h00.
  - For reads, s_miso is sampled in the last p_clk cycle of each high phase of bytes 4..7 and shifted MSB-first into the read register.
  - After the high phase of byte 7, go to DONE.
- DONE (one cycle):
  - s_css=1, s_clk=0, s_mosi=0, p_ready=1.
  - For reads, p_rdata = assembled word; it stays stable until the next read completes.
  - Next state is IDLE.
- Latency: p_ready is high exactly 1+8*CLK_DIV cycles after the first access-phase edge (17 cycles at CLK_DIV=2).
- p_ready is 0 in all other cycles. Writes leave p_rdata unchanged.
- Inputs that change during SHIFT are ignored because they were latched. If p_sel_x or p_enable drops mid-frame, the frame still completes and p_ready still pulses.
- A new access is accepted only in IDLE. Back-to-back accesses have at least one IDLE cycle between DONE and the next s_css fall.
- s_clk toggles only while s_css=0.

Optional Feature:
- Macro: APB_SLVERR_EN.
- When defined:
  - Adds output p_slverr (1 bit, reset 0).
  - An access with p_addr[1:0]!=0 or p_addr[31:24]!=0 generates no SPI frame.
  - Instead the block goes straight to DONE on the next cycle with p_ready=1 and p_slverr=1; p_rdata is unchanged.
  - p_slverr is 0 in every other DONE.
- When undefined: no p_slverr port; those address bits are ignored.

Test Plan:
- Reset: hold p_reset=1 for 2 cycles -> s_css=1, s_clk=0, s_mosi=0, p_ready=0, p_rdata=0.
- Write, p_addr=0, p_wdata=32'hFF00FF00 -> s_mosi bytes 02,00,00,00,FF,00,FF,00 on 8 s_clk rises; p_ready pulses 17 cycles after access start; s_css returns high.
- Read, p_addr=0, slave model returns FF,00,FF,00 on bytes 4..7 -> s_mosi 01,00,00,00,00,00,00,00; p_rdata=32'hFF00FF00 when p_ready=1.
- Write, p_addr=32'h00123456 -> address bytes 12,34,56; p_wdata=32'hA5A5_0F0F -> data bytes A5,A5,0F,0F.
- Assert p_reset during byte 5 of a write -> s_css=1 next cycle, no p_ready. A following read completes normally with 17-cycle latency.
- With APB_SLVERR_EN, read at p_addr=32'h00000002 -> s_css stays 1; p_ready=1 and p_slverr=1 one cycle after access start; p_rdata unchanged.

Source files
------------

// File: rtl/apb_spi_nor_controller.sv
// APB3 slave issuing one 8-byte byte-parallel SPI frame (cmd, 3 addr, 4 data) per access.
// Optional macro APB_SLVERR_EN adds p_slverr and rejects misaligned/out-of-range addresses.
module apb_spi_nor_controller #(
    parameter int unsigned CLK_DIV = 2,
    parameter logic [7:0]  WR_CMD  = 8'h02,
    parameter logic [7:0]  RD_CMD  = 8'h01
) (
    input  logic        p_clk,
    input  logic        p_reset,
    input  logic [31:0] p_addr,
    input  logic        p_write,
    input  logic        p_sel_x,
    input  logic        p_enable,
    input  logic [31:0] p_wdata,
    output logic [31:0] p_rdata,
    output logic        p_ready,
`ifdef APB_SLVERR_EN
    output logic        p_slverr,
`endif
    output logic [7:0]  s_mosi,
    input  logic [7:0]  s_miso,
    output logic        s_clk,
    output logic        s_css
);

    localparam int unsigned HALF = CLK_DIV / 2;
    localparam int unsigned PW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state_q, state_d;
    logic [2:0]     byte_q;
    logic [PW-1:0]  phase_q;
    logic [63:0]    frame_q;
    logic           is_rd_q;
    logic           err_q;
    logic [23:0]    rd_sh_q;
    logic [31:0]    rdata_q;
    logic           start;
    logic           bad_addr;
    logic           slot_end;
    logic           last_slot;

`ifdef APB_SLVERR_EN
    assign bad_addr = (p_addr[1:0] != 2'b00) || (p_addr[31:24] != 8'h00);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{p_addr[31:24], p_addr[1:0]};
    assign bad_addr = 1'b0;
`endif

    assign start     = p_sel_x & p_enable & ~p_ready;
    assign slot_end  = (phase_q == PW'(CLK_DIV - 1));
    assign last_slot = slot_end && (byte_q == 3'd7);
    assign p_rdata   = rdata_q;

    always_ff @(posedge p_clk) begin
        if (p_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        s_css   = 1'b1;
        s_clk   = 1'b0;
        s_mosi  = '0;
        p_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = bad_addr ? DONE : SHIFT;
            end
            SHIFT: begin
                s_css  = 1'b0;
                s_clk  = (phase_q >= PW'(HALF));
                s_mosi = frame_q[63:56];
                if (last_slot) state_d = DONE;
            end
            DONE: begin
                p_ready = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Pins show reset values in every reset cycle, not just after the first edge.
        if (p_reset) begin
            s_css   = 1'b1;
            s_clk   = 1'b0;
            s_mosi  = '0;
            p_ready = 1'b0;
        end
    end

`ifdef APB_SLVERR_EN
    assign p_slverr = (state_q == DONE) && err_q && !p_reset;
`endif

    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            byte_q  <= '0;
            phase_q <= '0;
            frame_q <= '0;
            is_rd_q <= 1'b0;
            err_q   <= 1'b0;
            rd_sh_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        byte_q  <= '0;
                        phase_q <= '0;
                        frame_q <= {p_write ? WR_CMD : RD_CMD, p_addr[23:0],
                                    p_write ? p_wdata : 32'h0};
                        is_rd_q <= ~p_write;
                        err_q   <= bad_addr;
                    end
                end
                SHIFT: begin
                    if (slot_end) begin
                        phase_q <= '0;
                        byte_q  <= byte_q + 3'd1;
                        frame_q <= {frame_q[55:0], 8'h00};
                        // Data bytes 4..7 carry read data; the final one lands straight in p_rdata.
                        if (is_rd_q && byte_q[2]) rd_sh_q <= {rd_sh_q[15:0], s_miso};
                        if (is_rd_q && last_slot) rdata_q <= {rd_sh_q, s_miso};
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_spi_nor_controller.sv
// Self-checking bench for apb_spi_nor_controller: directed and random APB frames against a byte-list model.
module tb_apb_spi_nor_controller;

    localparam int unsigned CLK_DIV = 2;
    localparam logic [7:0]  WR_CMD  = 8'h02;
    localparam logic [7:0]  RD_CMD  = 8'h01;
    localparam int          LAT     = 1 + 8 * CLK_DIV;

    logic        p_clk = 1'b0;
    logic        p_reset = 1'b1;
    logic [31:0] p_addr = '0;
    logic        p_write = 1'b0;
    logic        p_sel_x = 1'b0;
    logic        p_enable = 1'b0;
    logic [31:0] p_wdata = '0;
    logic [31:0] p_rdata;
    logic        p_ready;
`ifdef APB_SLVERR_EN
    logic        p_slverr;
`endif
    logic [7:0]  s_mosi;
    logic [7:0]  s_miso = '0;
    logic        s_clk;
    logic        s_css;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_rdata = '0;

    always #5 p_clk = ~p_clk;

    apb_spi_nor_controller #(
        .CLK_DIV(CLK_DIV),
        .WR_CMD (WR_CMD),
        .RD_CMD (RD_CMD)
    ) dut (
        .p_clk   (p_clk),
        .p_reset (p_reset),
        .p_addr  (p_addr),
        .p_write (p_write),
        .p_sel_x (p_sel_x),
        .p_enable(p_enable),
        .p_wdata (p_wdata),
        .p_rdata (p_rdata),
        .p_ready (p_ready),
`ifdef APB_SLVERR_EN
        .p_slverr(p_slverr),
`endif
        .s_mosi  (s_mosi),
        .s_miso  (s_miso),
        .s_clk   (s_clk),
        .s_css   (s_css)
    );

    // Setup phase on one cycle, access phase from the following posedge (edge A).
    task automatic start_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge p_clk);
        p_sel_x  = 1'b1;
        p_enable = 1'b0;
        p_write  = wr;
        p_addr   = addr;
        p_wdata  = wdata;
        @(posedge p_clk);
        #1 p_enable = 1'b1;
    endtask

    // Sample index c is the negedge c edges after edge A; p_ready is due at c == LAT.
    task automatic run_frame(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] miso_word, input bit drop_sel, input bit keep_sel);
        logic [7:0] exp_b [8];
        logic [7:0] got [$];
        int lat = -1;
        int rises = 0;
        int viol = 0;
        logic prev_clk = 1'b0;
        exp_b[0] = wr ? WR_CMD : RD_CMD;
        exp_b[1] = addr[23:16];
        exp_b[2] = addr[15:8];
        exp_b[3] = addr[7:0];
        exp_b[4] = wr ? wdata[31:24] : 8'h00;
        exp_b[5] = wr ? wdata[23:16] : 8'h00;
        exp_b[6] = wr ? wdata[15:8]  : 8'h00;
        exp_b[7] = wr ? wdata[7:0]   : 8'h00;
        for (int c = 0; c <= 60; c++) begin
            @(negedge p_clk);
            if (c == 0) begin
                checks++;
                if (s_css !== 1'b1 || p_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_gap: s_css=%b p_ready=%b, required s_css=1 p_ready=0", s_css, p_ready);
                end
            end
            if (s_css && s_clk) viol++;
            if (s_clk && !prev_clk) begin
                got.push_back(s_mosi);
                rises++;
                if (rises >= 5 && rises <= 8) s_miso = miso_word[8*(8-rises) +: 8];
            end
            prev_clk = s_clk;
            if (drop_sel && c == 6) begin
                p_sel_x  = 1'b0;
                p_enable = 1'b0;
            end
            if (p_ready) begin
                lat = c;
                break;
            end
        end
        if (!wr) model_rdata = miso_word;
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL latency: got %0d cycles, required %0d", lat, LAT);
        end
        checks++;
        if (got.size() != 8) begin
            errors++;
            $display("FAIL byte_count: got %0d s_clk rises, required 8", got.size());
        end
        for (int i = 0; i < 8; i++) begin
            if (i < got.size()) begin
                checks++;
                if (got[i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL mosi_byte%0d: got %02h, required %02h", i, got[i], exp_b[i]);
                end
            end
        end
        checks++;
        if (p_rdata !== model_rdata) begin
            errors++;
            $display("FAIL rdata: got %08h, required %08h", p_rdata, model_rdata);
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL sclk_gating: %0d cycles with s_clk=1 while s_css=1, required 0", viol);
        end
`ifdef APB_SLVERR_EN
        checks++;
        if (p_slverr !== 1'b0) begin
            errors++;
            $display("FAIL slverr_ok: got %b, required 0", p_slverr);
        end
`endif
        s_miso = '0;
        if (!keep_sel) begin
            p_sel_x  = 1'b0;
            p_enable = 1'b0;
            @(negedge p_clk);
            checks++;
            if (p_ready !== 1'b0 || s_css !== 1'b1) begin
                errors++;
                $display("FAIL ready_pulse: p_ready=%b s_css=%b, required 0 and 1", p_ready, s_css);
            end
        end
    endtask

    task automatic test_reset;
        p_reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge p_clk);
            checks++;
            if (s_css !== 1'b1 || s_clk !== 1'b0 || s_mosi !== 8'h00 || p_ready !== 1'b0 || p_rdata !== 32'h0) begin
                errors++;
                $display("FAIL reset_state: css=%b clk=%b mosi=%02h ready=%b rdata=%08h, required 1 0 00 0 00000000",
                         s_css, s_clk, s_mosi, p_ready, p_rdata);
            end
        end
        p_reset = 1'b0;
        model_rdata = '0;
    endtask

    task automatic test_directed;
        start_access(1'b1, 32'h0, 32'hFF00FF00);
        run_frame(1'b1, 32'h0, 32'hFF00FF00, 32'h0, 1'b0, 1'b0);
        start_access(1'b0, 32'h0, 32'h0);
        run_frame(1'b0, 32'h0, 32'h0, 32'hFF00FF00, 1'b0, 1'b0);
        start_access(1'b1, 32'h00123456, 32'hA5A50F0F);
        run_frame(1'b1, 32'h00123456, 32'hA5A50F0F, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 12; n++) begin
            logic        wr    = 1'($urandom_range(0, 1));
            logic [31:0] addr  = $urandom;
            logic [31:0] wdata = $urandom;
            logic [31:0] miso  = $urandom;
            bit          drop  = ($urandom_range(0, 3) == 0);
`ifdef APB_SLVERR_EN
            addr = {8'h00, addr[23:2], 2'b00};
`endif
            start_access(wr, addr, wdata);
            run_frame(wr, addr, wdata, miso, drop, 1'b0);
        end
    endtask

    task automatic test_back_to_back;
        start_access(1'b1, 32'h00ABCDEC, 32'h13579BDF);
        run_frame(1'b1, 32'h00ABCDEC, 32'h13579BDF, 32'h0, 1'b0, 1'b1);
        p_write = 1'b0;
        p_addr  = 32'h00004444;
        run_frame(1'b0, 32'h00004444, 32'h0, 32'h89ABCDEF, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midframe;
        int   rises = 0;
        int   seen_ready = 0;
        logic prev_clk = 1'b0;
        start_access(1'b1, 32'h00555554, 32'hDEADBEEF);
        for (int c = 0; c < 40 && rises < 6; c++) begin
            @(negedge p_clk);
            if (s_clk && !prev_clk) rises++;
            prev_clk = s_clk;
        end
        checks++;
        if (rises != 6) begin
            errors++;
            $display("FAIL reach_byte5: got %0d rises, required 6", rises);
        end
        p_reset = 1'b1;
        @(posedge p_clk);
        #1;
        checks++;
        if (s_css !== 1'b1 || s_clk !== 1'b0 || p_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort: css=%b clk=%b ready=%b, required 1 0 0", s_css, s_clk, p_ready);
        end
        @(negedge p_clk);
        p_reset  = 1'b0;
        p_sel_x  = 1'b0;
        p_enable = 1'b0;
        model_rdata = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge p_clk);
            if (p_ready) seen_ready++;
        end
        checks++;
        if (seen_ready != 0) begin
            errors++;
            $display("FAIL no_ready_after_abort: got %0d pulses, required 0", seen_ready);
        end
        start_access(1'b0, 32'h00000100, 32'h0);
        run_frame(1'b0, 32'h00000100, 32'h0, 32'h0F1E2D3C, 1'b0, 1'b0);
    endtask

`ifdef APB_SLVERR_EN
    task automatic test_slverr;
        logic [31:0] addrs [2];
        addrs[0] = 32'h00000002;
        addrs[1] = 32'h01000000;
        for (int k = 0; k < 2; k++) begin
            int lat = -1;
            int css_low = 0;
            start_access(k == 1, addrs[k], 32'hCAFEF00D);
            for (int c = 0; c <= 20; c++) begin
                @(negedge p_clk);
                if (!s_css) css_low++;
                if (p_ready) begin
                    lat = c;
                    break;
                end
            end
            checks++;
            if (lat != 1 || p_slverr !== 1'b1) begin
                errors++;
                $display("FAIL slverr: latency %0d slverr=%b, required 1 and 1", lat, p_slverr);
            end
            checks++;
            if (css_low != 0 || p_rdata !== model_rdata) begin
                errors++;
                $display("FAIL slverr_noframe: css_low=%0d rdata=%08h, required 0 and %08h", css_low, p_rdata, model_rdata);
            end
            p_sel_x  = 1'b0;
            p_enable = 1'b0;
            @(negedge p_clk);
            checks++;
            if (p_ready !== 1'b0 || p_slverr !== 1'b0) begin
                errors++;
                $display("FAIL slverr_pulse: ready=%b slverr=%b, required 0 0", p_ready, p_slverr);
            end
        end
    endtask
`endif

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_reset_midframe;
`ifdef APB_SLVERR_EN
        test_slverr;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
